// File: rtl/sdram_arbiter_rr.sv
// Round-robin SDRAM slot arbiter for NCH clients.
// Splits 8/16/32-bit big-endian accesses into 16-bit SDRAM word ops.
module sdram_arbiter_rr #(
    parameter int NCH           = 3,
    parameter int ABUS_WIDTH    = 23,
    parameter int REFRESH_EVERY = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      access_slot,
    input  logic [NCH-1:0]            req,
    input  logic [NCH-1:0]            we,
    input  logic [2*NCH-1:0]          size,
    input  logic [NCH*ABUS_WIDTH-1:0] adrs,
    input  logic [NCH*32-1:0]         wdata,
    output logic [NCH-1:0]            ack,
    output logic [31:0]               rdata,
    output logic [ABUS_WIDTH-2:0]     sdram_addr,
    output logic                      sdram_read,
    output logic                      sdram_write,
    output logic                      sdram_lb,
    output logic                      sdram_ub,
    output logic                      sdram_refresh,
    output logic [15:0]               sdram_do,
    input  logic [15:0]               sdram_di,
    input  logic                      sdram_busy
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW = $clog2(REFRESH_EVERY);
    localparam int WW = ABUS_WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

    typedef struct packed {
        logic [WW-1:0] addr;
        logic          lb;
        logic          ub;
        logic [15:0]   dout;
    } op_t;

    // Address, lane enables and write data of sub-op i of an access.
    function automatic op_t split(
        input logic [ABUS_WIDTH-1:0] a,
        input logic [1:0]            sz,
        input logic [31:0]           d,
        input logic [1:0]            i
    );
        op_t o;
        o.addr = a[ABUS_WIDTH-1:1] + WW'(i);
        o.lb   = 1'b0;
        o.ub   = 1'b0;
        o.dout = 16'h0000;
        case ({sz, a[0]})
            3'b000: begin
                o.ub   = 1'b1;
                o.dout = {d[7:0], d[7:0]};
            end
            3'b001: begin
                o.lb   = 1'b1;
                o.dout = {d[7:0], d[7:0]};
            end
            3'b010: begin
                o.lb   = 1'b1;
                o.ub   = 1'b1;
                o.dout = d[15:0];
            end
            3'b011: begin
                if (i == 2'd0) begin
                    o.lb   = 1'b1;
                    o.dout = {8'h00, d[15:8]};
                end else begin
                    o.ub   = 1'b1;
                    o.dout = {d[7:0], 8'h00};
                end
            end
            3'b100: begin
                o.lb   = 1'b1;
                o.ub   = 1'b1;
                o.dout = (i == 2'd0) ? d[31:16] : d[15:0];
            end
            3'b101: begin
                if (i == 2'd0) begin
                    o.lb   = 1'b1;
                    o.dout = {8'h00, d[31:24]};
                end else if (i == 2'd1) begin
                    o.lb   = 1'b1;
                    o.ub   = 1'b1;
                    o.dout = d[23:8];
                end else begin
                    o.ub   = 1'b1;
                    o.dout = {d[7:0], 8'h00};
                end
            end
            default: ;
        endcase
        return o;
    endfunction

    // True when sub-op i is the final one of the access.
    function automatic logic op_last(
        input logic [1:0] sz,
        input logic       a0,
        input logic [1:0] i
    );
        logic [1:0] n;
        case ({sz, a0})
            3'b011:  n = 2'd1;
            3'b100:  n = 2'd1;
            3'b101:  n = 2'd2;
            default: n = 2'd0;
        endcase
        return i == n;
    endfunction

    // Winner searching upward from rr+1; MSB flags that anyone won.
    function automatic logic [CW:0] rr_pick(
        input logic [NCH-1:0] p,
        input logic [CW-1:0]  rr
    );
        logic [CW:0]   r;
        logic [CW-1:0] s;
        int            c;
        r = '0;
        for (int i = NCH; i >= 1; i--) begin
            c = (int'(rr) + i) % NCH;
            s = CW'(c);
            if (p[s]) r = {1'b1, s};
        end
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [SW-1:0]       slot_q, slot_d;
    logic [CW-1:0]       rr_q, rr_d;
    logic [CW-1:0]       grant_q, grant_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic [ABUS_WIDTH-1:0] adrs_q, adrs_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [1:0]          idx_q, idx_d;
    logic [31:0]         asm_q, asm_d;
    logic [NCH-1:0]      ack_q, ack_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [WW-1:0]       addr_q, addr_d;
    logic                lb_q, lb_d;
    logic                ub_q, ub_d;
    logic [15:0]         do_q, do_d;

    logic                refresh_slot;
    logic                client_slot;
    logic                fire;
    logic [CW:0]         arb;
    logic                sel_we;
    logic [1:0]          sel_size;
    logic [ABUS_WIDTH-1:0] sel_adrs;
    logic [31:0]         sel_wdata;
    op_t                 first_op;
    op_t                 next_op;
    logic [31:0]         captured;

    // Slot classification and the combinational command strobes.
    always_comb begin
        refresh_slot  = (slot_q == SW'(REFRESH_EVERY - 1));
        client_slot   = access_slot & ~refresh_slot;
        sdram_refresh = access_slot & refresh_slot;
        fire          = (state_q == S_ISSUE) & client_slot & ~sdram_busy;
        sdram_read    = fire & ~we_q;
        sdram_write   = fire & we_q;
        slot_d        = slot_q;
        if (access_slot) slot_d = refresh_slot ? '0 : slot_q + SW'(1);
    end

    // Arbitration and selection of the winning channel's request fields.
    always_comb begin
        arb       = rr_pick(req & ~ack_q, rr_q);
        sel_we    = 1'b0;
        sel_size  = 2'b00;
        sel_adrs  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (arb[CW-1:0] == CW'(i)) begin
                sel_we    = we[i];
                sel_size  = size[2*i +: 2];
                sel_adrs  = adrs[i*ABUS_WIDTH +: ABUS_WIDTH];
                sel_wdata = wdata[i*32 +: 32];
            end
        end
        first_op = split(sel_adrs, sel_size, sel_wdata, 2'd0);
        next_op  = split(adrs_q, size_q, wdata_q, idx_q + 2'd1);
        captured = asm_q;
        if (lb_q && ub_q)
            captured = {asm_q[15:0], sdram_di};
        else if (ub_q)
            captured = {asm_q[23:0], sdram_di[15:8]};
        else if (lb_q)
            captured = {asm_q[23:0], sdram_di[7:0]};
    end

    // Transaction FSM: next state, latched request and registered outputs.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        we_d    = we_q;
        size_d  = size_q;
        adrs_d  = adrs_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        lb_d    = lb_q;
        ub_d    = ub_q;
        do_d    = do_q;
        ack_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (arb[CW]) begin
                    grant_d = arb[CW-1:0];
                    we_d    = sel_we;
                    size_d  = sel_size;
                    adrs_d  = sel_adrs;
                    wdata_d = sel_wdata;
                    idx_d   = 2'd0;
                    asm_d   = '0;
                    if (sel_size == 2'b11) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = S_ISSUE;
                        addr_d  = first_op.addr;
                        lb_d    = first_op.lb;
                        ub_d    = first_op.ub;
                        do_d    = first_op.dout;
                    end
                end
            end
            S_ISSUE: begin
                if (fire) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!sdram_busy) begin
                    if (!we_q) asm_d = captured;
                    if (op_last(size_q, adrs_q[0], idx_q)) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = S_ISSUE;
                        idx_d   = idx_q + 2'd1;
                        addr_d  = next_op.addr;
                        lb_d    = next_op.lb;
                        ub_d    = next_op.ub;
                        do_d    = next_op.dout;
                    end
                end
            end
            S_ACK: begin
                for (int i = 0; i < NCH; i++)
                    ack_d[i] = (grant_q == CW'(i));
                rdata_d = asm_q;
                rr_d    = grant_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            rr_q    <= CW'(NCH - 1);
            grant_q <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            adrs_q  <= '0;
            wdata_q <= '0;
            idx_q   <= 2'd0;
            asm_q   <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            lb_q    <= 1'b0;
            ub_q    <= 1'b0;
            do_q    <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            size_q  <= size_d;
            adrs_q  <= adrs_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            lb_q    <= lb_d;
            ub_q    <= ub_d;
            do_q    <= do_d;
        end
    end

    assign ack        = ack_q;
    assign rdata      = rdata_q;
    assign sdram_addr = addr_q;
    assign sdram_lb   = lb_q;
    assign sdram_ub   = ub_q;
    assign sdram_do   = do_q;

endmodule
